fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/return_stack.sv | 58 +++++
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: address width, interrupt vector
// and the sequencer FSM state encoding.
package fetch_pkg;

   localparam int ADDR_W = 13;
   localparam logic [ADDR_W-1:0] IRQ_VECTOR = 13'h0010;

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

endpackage

// File: rtl/return_stack.sv
// Circular hardware return-address stack: push, pop and replace-top.
// A push when full overwrites the oldest entry and the count saturates.
module return_stack
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              replace,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  top_idx;
   logic [CNT_W-1:0]  count;

   // ptr is the next free slot; with a full stack it also names the oldest entry
   assign top_idx = ptr - PTR_W'(1);
   assign top     = mem[top_idx];
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));

   // NOTE: the storage array has no reset; only ptr/count define validity, and
   // leaving it unreset lets it map onto plain flops or distributed RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end else if (replace) begin
         mem[top_idx] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full) begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr   <= ptr - PTR_W'(1);
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// PC load control: arbitrates sequential fetch, stall hold, EX redirects and
// interrupt entry/exit, and flushes IF/ID for FLUSH_CYCLES after any redirect.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int RAS_DEPTH    = 8,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              call,
   input  logic [ADDR_W-1:0] link_addr,
   input  logic              ret,
   input  logic [ADDR_W-1:0] resume_addr,
   input  logic              irq_req,
   input  logic              reti,
   output logic              pc_load_en,
   output logic [ADDR_W-1:0] pc_load_addr,
   output logic              flush,
   output logic              irq_ack,
   output logic              in_isr,
   output logic              ras_overflow,
   output logic              ras_underflow
);

   localparam int FCNT_W = 2;

   state_t            state, state_next;
   logic [FCNT_W-1:0] flush_cnt, flush_cnt_next;
   logic [ADDR_W-1:0] epc;
   logic              redirect;
   logic              epc_load, isr_set, isr_clr, set_ovf, set_unf;
   logic              ras_push, ras_pop, ras_replace, ras_empty, ras_full;
   logic [ADDR_W-1:0] ras_top;

   return_stack #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .replace   (ras_replace),
      .push_data (link_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   assign flush = (state == FLUSH);

   // NOTE: every output of this block gets a default first, so no path through
   // the priority chain can leave a signal unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      pc_load_en     = 1'b0;
      pc_load_addr   = '0;
      irq_ack        = 1'b0;
      redirect       = 1'b0;
      epc_load       = 1'b0;
      isr_set        = 1'b0;
      isr_clr        = 1'b0;
      set_ovf        = 1'b0;
      set_unf        = 1'b0;
      ras_push       = 1'b0;
      ras_pop        = 1'b0;
      ras_replace    = 1'b0;

      if (state == RUN) begin
         if (reti && in_isr) begin
            redirect     = 1'b1;
            pc_load_addr = epc;
            isr_clr      = 1'b1;
         end else if (ret) begin
            redirect = 1'b1;
            // ret+call swaps the top entry; on an empty stack it degrades to a push
            if (ras_empty) begin
               set_unf  = 1'b1;
               ras_push = br_taken && call;
            end else if (br_taken && call) begin
               pc_load_addr = ras_top;
               ras_replace  = 1'b1;
            end else begin
               pc_load_addr = ras_top;
               ras_pop      = 1'b1;
            end
         end else if (br_taken) begin
            redirect     = 1'b1;
            pc_load_addr = br_target;
            ras_push     = call;
            set_ovf      = call && ras_full;
         end else if (irq_req && !in_isr && !stall) begin
            redirect     = 1'b1;
            pc_load_addr = IRQ_VECTOR;
            epc_load     = 1'b1;
            isr_set      = 1'b1;
            irq_ack      = 1'b1;
         end
      end else begin
         if (flush_cnt == '0) begin
            state_next = RUN;
         end else begin
            flush_cnt_next = flush_cnt - FCNT_W'(1);
         end
      end

      if (redirect) begin
         pc_load_en     = 1'b1;
         state_next     = FLUSH;
         flush_cnt_next = FCNT_W'(FLUSH_CYCLES - 1);
      end else if (stall) begin
         pc_load_en   = 1'b1;
         pc_load_addr = pc_addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= RUN;
         flush_cnt     <= '0;
         epc           <= '0;
         in_isr        <= 1'b0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
         if (epc_load) begin
            epc <= resume_addr;
         end
         if (isr_set) begin
            in_isr <= 1'b1;
         end else if (isr_clr) begin
            in_isr <= 1'b0;
         end
         if (set_ovf) begin
            ras_overflow <= 1'b1;
         end
         if (set_unf) begin
            ras_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural PC register closes the loop,
// and each vector carries hand-computed expected load/flush/status values.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] pc_addr;
   logic              stall = 1'b0;
   logic              br_taken = 1'b0;
   logic [ADDR_W-1:0] br_target = '0;
   logic              call = 1'b0;
   logic [ADDR_W-1:0] link_addr = '0;
   logic              ret = 1'b0;
   logic [ADDR_W-1:0] resume_addr = '0;
   logic              irq_req = 1'b0;
   logic              reti = 1'b0;
   logic              pc_load_en;
   logic [ADDR_W-1:0] pc_load_addr;
   logic              flush;
   logic              irq_ack;
   logic              in_isr;
   logic              ras_overflow;
   logic              ras_underflow;

   logic [ADDR_W-1:0] pc;
   int                n_checks = 0;
   int                n_errors = 0;

   fetch_sequencer #(
      .RAS_DEPTH    (8),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_addr       (pc_addr),
      .stall         (stall),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .call          (call),
      .link_addr     (link_addr),
      .ret           (ret),
      .resume_addr   (resume_addr),
      .irq_req       (irq_req),
      .reti          (reti),
      .pc_load_en    (pc_load_en),
      .pc_load_addr  (pc_load_addr),
      .flush         (flush),
      .irq_ack       (irq_ack),
      .in_isr        (in_isr),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   // program counter the sequencer drives
   always @(posedge clk or negedge reset) begin
      if (!reset) pc <= '0;
      else if (pc_load_en) pc <= pc_load_addr;
      else pc <= pc + 13'd1;
   end
   assign pc_addr = pc;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clear_ex();
      br_taken = 1'b0;
      call     = 1'b0;
      ret      = 1'b0;
      reti     = 1'b0;
      stall    = 1'b0;
   endtask

   task automatic drain_flush();
      clear_ex();
      repeat (2) tick();
   endtask

   task automatic do_call(input int target, input int link);
      br_taken  = 1'b1;
      call      = 1'b1;
      br_target = 13'(target);
      link_addr = 13'(link);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_en", int'(pc_load_en), 0);
      check("rst_flush", int'(flush), 0);
      check("rst_isr", int'(in_isr), 0);
      check("rst_ovf", int'(ras_overflow), 0);
      check("rst_unf", int'(ras_underflow), 0);
      check("rst_ack", int'(irq_ack), 0);
      reset = 1'b1;

      // free-running increment
      for (int i = 0; i < 5; i++) begin
         sample();
         check("seq_en", int'(pc_load_en), 0);
         check("seq_pc", int'(pc_addr), i);
         check("seq_flush", int'(flush), 0);
         tick();
      end

      // stall holds PC at 5 for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("stall_en", int'(pc_load_en), 1);
         check("stall_addr", int'(pc_load_addr), 5);
         tick();
      end
      stall = 1'b0;
      sample();
      check("stall_hold_pc", int'(pc_addr), 5);
      check("stall_rel_en", int'(pc_load_en), 0);
      tick();
      sample();
      check("stall_resume_pc", int'(pc_addr), 6);
      tick();

      // branch overrides stall, then redirects ignored during the flush
      br_taken = 1'b1; br_target = 13'h100; stall = 1'b1;
      sample();
      check("br_en", int'(pc_load_en), 1);
      check("br_addr", int'(pc_load_addr), 'h100);
      check("br_flush_pre", int'(flush), 0);
      tick();
      stall = 1'b0; br_target = 13'h300;
      for (int i = 0; i < 2; i++) begin
         sample();
         check("br_flush", int'(flush), 1);
         check("br_flush_ignored", int'(pc_load_en), 0);
         tick();
      end
      clear_ex();
      sample();
      check("br_flush_end", int'(flush), 0);
      check("br_pc_after", int'(pc_addr), 'h102);
      tick();

      // call then ret
      do_call('h200, 'h011);
      sample();
      check("call_addr", int'(pc_load_addr), 'h200);
      tick();
      drain_flush();
      ret = 1'b1;
      sample();
      check("ret_en", int'(pc_load_en), 1);
      check("ret_addr", int'(pc_load_addr), 'h011);
      tick();
      drain_flush();

      // ret+call replaces top
      do_call('h500, 'h050);
      tick();
      drain_flush();
      do_call('h7ff, 'h060); ret = 1'b1;
      sample();
      check("retcall_addr", int'(pc_load_addr), 'h050);
      tick();
      drain_flush();
      ret = 1'b1;
      sample();
      check("retcall_top", int'(pc_load_addr), 'h060);
      tick();
      check("retcall_unf", int'(ras_underflow), 0);
      drain_flush();

      // nine calls overflow the 8-entry stack
      for (int k = 0; k < 9; k++) begin
         do_call('h400 + k, 'h020 + k);
         sample();
         check("call9_addr", int'(pc_load_addr), 'h400 + k);
         tick();
         check("call9_ovf", int'(ras_overflow), (k == 8) ? 1 : 0);
         drain_flush();
      end
      for (int k = 1; k <= 8; k++) begin
         ret = 1'b1;
         sample();
         check("ret9_addr", int'(pc_load_addr), 'h020 + 9 - k);
         tick();
         drain_flush();
      end
      check("ret9_unf_pre", int'(ras_underflow), 0);
      ret = 1'b1;
      sample();
      check("ret_empty_en", int'(pc_load_en), 1);
      check("ret_empty_addr", int'(pc_load_addr), 0);
      tick();
      check("ret_empty_unf", int'(ras_underflow), 1);
      drain_flush();

      // interrupt entry, masking, exit
      irq_req = 1'b1; resume_addr = 13'h040;
      sample();
      check("irq_ack", int'(irq_ack), 1);
      check("irq_addr", int'(pc_load_addr), 'h010);
      check("irq_en", int'(pc_load_en), 1);
      tick();
      check("irq_isr", int'(in_isr), 1);
      repeat (2) tick();
      sample();
      check("irq_masked_ack", int'(irq_ack), 0);
      check("irq_masked_en", int'(pc_load_en), 0);
      tick();
      irq_req = 1'b0;
      reti = 1'b1;
      sample();
      check("reti_en", int'(pc_load_en), 1);
      check("reti_addr", int'(pc_load_addr), 'h040);
      tick();
      reti = 1'b0;
      check("reti_isr", int'(in_isr), 0);
      for (int i = 0; i < 2; i++) begin
         sample();
         check("reti_flush", int'(flush), 1);
         tick();
      end
      sample();
      check("reti_flush_end", int'(flush), 0);
      tick();

      // reti outside an ISR is ignored
      reti = 1'b1;
      sample();
      check("reti_idle_en", int'(pc_load_en), 0);
      tick();
      reti = 1'b0;

      // irq deferred by stall
      irq_req = 1'b1; stall = 1'b1; resume_addr = 13'h077;
      sample();
      check("irq_stall_ack", int'(irq_ack), 0);
      check("irq_stall_addr", int'(pc_load_addr), int'(pc));
      tick();
      stall = 1'b0;
      sample();
      check("irq_after_stall", int'(irq_ack), 1);
      tick();
      irq_req = 1'b0;
      drain_flush();

      // reset mid-flush with in_isr and three RAS entries
      for (int k = 0; k < 3; k++) begin
         do_call('h600 + k, 'h030 + k);
         tick();
         clear_ex();
         if (k < 2) repeat (2) tick();
      end
      #2;
      check("pre_rst_flush", int'(flush), 1);
      check("pre_rst_isr", int'(in_isr), 1);
      reset = 1'b0;
      #1;
      check("mid_rst_flush", int'(flush), 0);
      check("mid_rst_isr", int'(in_isr), 0);
      check("mid_rst_ovf", int'(ras_overflow), 0);
      check("mid_rst_unf", int'(ras_underflow), 0);
      check("mid_rst_en", int'(pc_load_en), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ret = 1'b1;
      sample();
      check("post_rst_ret_en", int'(pc_load_en), 1);
      check("post_rst_ret_addr", int'(pc_load_addr), 0);
      tick();
      check("post_rst_unf", int'(ras_underflow), 1);
      drain_flush();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
